// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic IDLE_LEVEL = 1'b1;

  // Mode 2'b11 is treated as no parity.
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick counter: flags the last tick of a bit (or of a double-length bit).
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic BCLK,
  input  logic reset_n,
  input  logic clear,
  input  logic len2x,
  output logic bit_end
);
  localparam int CW = $clog2(OVERSAMPLE) + 1;
  localparam logic [CW-1:0] LAST_1X = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] LAST_2X = CW'(2 * OVERSAMPLE - 1);

  logic [CW-1:0] tick_cnt;

  assign bit_end = (tick_cnt == (len2x ? LAST_2X : LAST_1X));

  always_ff @(posedge BCLK or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (clear || bit_end) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: holding buffer, frame FSM, shift register and bit counter.
//   state  | meaning
//   IDLE   | line high, waiting for a buffered word
//   START  | start bit (low)
//   DATA   | data bits, LSB first
//   PARITY | parity bit, only when enabled for this frame
//   STOP   | one or two stop bits; reloads directly when the buffer is full
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  BCLK,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] tx_din,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [1:0]            cfg_parity,
  input  logic                  cfg_two_stop,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);
  localparam int BCW = $clog2(DATA_WIDTH);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

  tx_state_t             state, state_nxt;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [1:0]            buf_par;
  logic                  buf_two_stop;
  logic                  full, full_nxt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt;
  logic [BCW-1:0]        bit_cnt, bit_cnt_nxt;
  logic                  par_bit, par_bit_nxt;
  logic                  par_en, par_en_nxt;
  logic                  two_stop, two_stop_nxt;
  logic                  accept, load, bit_end;

  assign tx_ready = ~full;
  assign accept   = tx_valid & tx_ready;
  assign tx_busy  = (state != IDLE);

  uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .BCLK    (BCLK),
    .reset_n (reset_n),
    .clear   (state == IDLE),
    .len2x   ((state == STOP) && two_stop),
    .bit_end (bit_end)
  );

  always_ff @(posedge BCLK or negedge reset_n) begin
    if (!reset_n) begin
      buf_data     <= '0;
      buf_par      <= PAR_NONE;
      buf_two_stop <= 1'b0;
    end else if (accept) begin
      buf_data     <= tx_din;
      buf_par      <= cfg_parity;
      buf_two_stop <= cfg_two_stop;
    end
  end

  always_ff @(posedge BCLK or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      full     <= 1'b0;
      shift    <= '0;
      bit_cnt  <= '0;
      par_bit  <= 1'b0;
      par_en   <= 1'b0;
      two_stop <= 1'b0;
    end else begin
      state    <= state_nxt;
      full     <= full_nxt;
      shift    <= shift_nxt;
      bit_cnt  <= bit_cnt_nxt;
      par_bit  <= par_bit_nxt;
      par_en   <= par_en_nxt;
      two_stop <= two_stop_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift;
    bit_cnt_nxt  = bit_cnt;
    par_bit_nxt  = par_bit;
    par_en_nxt   = par_en;
    two_stop_nxt = two_stop;
    load         = 1'b0;
    tx           = IDLE_LEVEL;
    tx_done      = 1'b0;

    case (state)
      IDLE: begin
        if (full) load = 1'b1;
      end
      START: begin
        tx = 1'b0;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        tx = shift[0];
        if (bit_end) begin
          shift_nxt   = shift >> 1;
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) state_nxt = par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        tx = par_bit;
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        if (bit_end) begin
          tx_done = 1'b1;
          if (full) load = 1'b1;
          else      state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Frame config and parity are frozen at load so mid-frame cfg changes are ignored.
    if (load) begin
      state_nxt    = START;
      shift_nxt    = buf_data;
      bit_cnt_nxt  = '0;
      par_en_nxt   = par_enabled(buf_par);
      par_bit_nxt  = (^buf_data) ^ (buf_par == PAR_ODD);
      two_stop_nxt = buf_two_stop;
    end

    full_nxt = full;
    if (load)   full_nxt = 1'b0;
    if (accept) full_nxt = 1'b1;
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench: stimulus queues expected frames, a line monitor decodes tx and compares.
module tb_uart_tx_frame;

  typedef struct {
    logic [9:0] lv;
    int         nbits;
    int         os;
    int         len;
    bit         b2b;
    bit         drop;
  } exp_t;

  logic       BCLK = 1'b0;
  logic       reset_n;
  logic [7:0] din;
  logic       vld, rdy;
  logic [1:0] par;
  logic       two;
  logic       tx_a, busy_a, done_a;
  logic [4:0] din5;
  logic       vld5, rdy5;
  logic [1:0] par5;
  logic       two5;
  logic       tx_b, busy_b, done_b;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_done [2];
  exp_t q0 [$];
  exp_t q1 [$];

  always #5 BCLK = ~BCLK;
  always @(posedge BCLK) cyc++;

  uart_tx_frame #(.OVERSAMPLE(16), .DATA_WIDTH(8)) dut (
    .BCLK(BCLK), .reset_n(reset_n), .tx_din(din), .tx_valid(vld), .tx_ready(rdy),
    .cfg_parity(par), .cfg_two_stop(two), .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a)
  );

  uart_tx_frame #(.OVERSAMPLE(4), .DATA_WIDTH(5)) dut5 (
    .BCLK(BCLK), .reset_n(reset_n), .tx_din(din5), .tx_valid(vld5), .tx_ready(rdy5),
    .cfg_parity(par5), .cfg_two_stop(two5), .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b)
  );

  function automatic void check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  function automatic logic cur_tx(input int which);
    return (which == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic cur_done(input int which);
    return (which == 0) ? done_a : done_b;
  endfunction

  function automatic logic cur_rdy(input int which);
    return (which == 0) ? rdy : rdy5;
  endfunction

  task automatic run_monitor(input int which);
    logic prev;
    logic lvl [512];
    int   n, start_c, errs, b;
    bit   aborted, timed_out;
    logic want;
    exp_t e;
    prev = 1'b1;
    while (1'b1) begin
      @(negedge BCLK);
      if (!reset_n) begin
        prev = 1'b1;
        continue;
      end
      if (prev && !cur_tx(which)) begin
        start_c = cyc; n = 0; aborted = 0; timed_out = 0;
        while (1'b1) begin
          if (!reset_n) begin aborted = 1; break; end
          lvl[n] = cur_tx(which);
          n++;
          if (cur_done(which)) break;
          if (n >= 400) begin timed_out = 1; break; end
          @(negedge BCLK);
        end
        if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
          total++; bad++;
          $display("FAIL unexpected_frame: dut %0d started a frame at cycle %0d, expected none", which, start_c);
        end else begin
          if (which == 0) e = q0.pop_front();
          else            e = q1.pop_front();
          check("frame_aborted", int'(aborted), int'(e.drop));
          if (!aborted) begin
            check("frame_timeout", int'(timed_out), 0);
            check("frame_len", n, e.len);
            errs = 0;
            for (int t = 0; t < n; t++) begin
              b = t / e.os;
              if (b == 0)            want = 1'b0;
              else if (b <= e.nbits) want = e.lv[b-1];
              else                   want = 1'b1;
              if (lvl[t] !== want) errs++;
            end
            check("frame_bits", errs, 0);
            if (e.b2b) check("b2b_gap", start_c, last_done[which] + 1);
            last_done[which] = start_c + n - 1;
          end
        end
      end
      prev = cur_tx(which);
    end
  endtask

  task automatic send(input int which, input logic [8:0] data, input logic [1:0] pm,
                      input logic ts, input logic pbit, input int len,
                      input bit b2b, input bit drop);
    exp_t e;
    int   dw, waited;
    dw = (which == 0) ? 8 : 5;
    e.lv = '0;
    for (int i = 0; i < dw; i++) e.lv[i] = data[i];
    e.nbits = dw;
    if (pm == 2'b01 || pm == 2'b10) begin
      e.lv[dw] = pbit;
      e.nbits  = dw + 1;
    end
    e.os = (which == 0) ? 16 : 4;
    e.len = len; e.b2b = b2b; e.drop = drop;
    if (which == 0) q0.push_back(e);
    else            q1.push_back(e);
    @(negedge BCLK);
    if (which == 0) begin din = data[7:0]; par = pm; two = ts; vld = 1'b1; end
    else begin din5 = data[4:0]; par5 = pm; two5 = ts; vld5 = 1'b1; end
    waited = 0;
    while (!cur_rdy(which) && waited < 1000) begin
      @(negedge BCLK);
      waited++;
    end
    check("accept_timeout", int'(waited >= 1000), 0);
    @(posedge BCLK);
    #1;
    if (which == 0) vld = 1'b0;
    else            vld5 = 1'b0;
  endtask

  task automatic wait_idle(input int which);
    int waited;
    waited = 0;
    while (waited < 2000) begin
      @(negedge BCLK);
      #1;
      if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) break;
      waited++;
    end
    check("drain_timeout", int'(waited >= 2000), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    din = '0; vld = 1'b0; par = 2'b00; two = 1'b0;
    din5 = '0; vld5 = 1'b0; par5 = 2'b00; two5 = 1'b0;
    last_done[0] = 0; last_done[1] = 0;
    fork
      run_monitor(0);
      run_monitor(1);
    join_none

    repeat (3) @(negedge BCLK);
    check("rst_tx", int'(tx_a), 1);
    check("rst_ready", int'(rdy), 1);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_tx5", int'(tx_b), 1);
    check("rst_ready5", int'(rdy5), 1);
    reset_n = 1'b1;
    repeat (2) @(negedge BCLK);

    // 8N1 0x55, latency and ready timing
    send(0, 9'h055, 2'b00, 1'b0, 1'b0, 160, 0, 0);
    check("ready_low_after_accept", int'(rdy), 0);
    check("tx_idle_at_accept", int'(tx_a), 1);
    @(posedge BCLK); #1;
    check("start_latency", int'(tx_a), 0);
    check("ready_back", int'(rdy), 1);
    check("busy_in_frame", int'(busy_a), 1);
    wait_idle(0);
    @(posedge BCLK); #1;
    check("busy_after_frame", int'(busy_a), 0);
    check("tx_idle_after_frame", int'(tx_a), 1);

    // parity frames
    send(0, 9'h007, 2'b01, 1'b0, 1'b1, 176, 0, 0);
    wait_idle(0);
    send(0, 9'h000, 2'b10, 1'b0, 1'b1, 176, 0, 0);
    wait_idle(0);

    // two stop bits, cfg toggled mid-frame
    send(0, 9'h0A3, 2'b00, 1'b1, 1'b0, 176, 0, 0);
    repeat (40) @(negedge BCLK);
    two = 1'b0;
    par = 2'b01;
    wait_idle(0);

    // back-to-back
    par = 2'b00;
    send(0, 9'h001, 2'b00, 1'b0, 1'b0, 160, 0, 0);
    check("b2b_ready_low", int'(rdy), 0);
    @(posedge BCLK); #1;
    check("b2b_ready_high", int'(rdy), 1);
    send(0, 9'h080, 2'b00, 1'b0, 1'b0, 160, 1, 0);
    repeat (100) @(negedge BCLK);
    check("b2b_ready_held", int'(rdy), 0);
    wait_idle(0);

    // reset during data bit 4 (0xE5 has bit 4 = 0)
    send(0, 9'h0E5, 2'b00, 1'b0, 1'b0, 160, 0, 1);
    repeat (88) @(negedge BCLK);
    check("bit4_level", int'(tx_a), 0);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_tx", int'(tx_a), 1);
    check("midrst_ready", int'(rdy), 1);
    check("midrst_busy", int'(busy_a), 0);
    check("midrst_done", int'(done_a), 0);
    repeat (3) @(negedge BCLK);
    reset_n = 1'b1;
    wait_idle(0);
    send(0, 9'h03C, 2'b00, 1'b0, 1'b0, 160, 0, 0);
    wait_idle(0);

    // 5-bit word, OVERSAMPLE 4, odd parity
    send(1, 9'h01F, 2'b10, 1'b0, 1'b0, 32, 0, 0);
    wait_idle(1);

    repeat (5) @(negedge BCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
